// File: rtl/rrf_commit_tracker.sv
// In-order commit tracker for the rename register file: records allocation and
// execution-finish per RRF entry and retires up to two finished entries per cycle from the head.
module rrf_commit_tracker #(
    parameter int RRF_NUM = 64,
    parameter int RRF_SEL = 6
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               dp_alloc_en_i,
    input  logic [RRF_SEL-1:0] dp_alloc_tag_i,
    input  logic [1:0]         ex_fin_en_i,
    input  logic [RRF_SEL-1:0] ex_fin_tag0_i,
    input  logic [RRF_SEL-1:0] ex_fin_tag1_i,
    input  logic               com_stall_i,
    output logic [1:0]         com_inst_num_o,
    output logic [1:0]         com_en_o,
    output logic [RRF_SEL-1:0] comptr_o,
    output logic [RRF_SEL-1:0] comptr2_o,
    output logic [RRF_SEL:0]   occupancy_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               alloc_err_o
);

    localparam logic [RRF_SEL:0]   OCC_MAX = (RRF_SEL+1)'(RRF_NUM);
    localparam logic [RRF_SEL:0]   OCC_TWO = (RRF_SEL+1)'(2);
    localparam logic [RRF_SEL-1:0] TAG_ONE = RRF_SEL'(1);

    logic [RRF_NUM-1:0] valid_q, valid_d;
    logic [RRF_NUM-1:0] fin_q, fin_d;
    logic [RRF_SEL-1:0] head_q, head_d;
    logic [RRF_SEL-1:0] head1;
    logic [RRF_SEL-1:0] tail_q, tail_d;
    logic [RRF_SEL:0]   occ_q, occ_d;
    logic               err_q, err_d;
    logic               alloc_acc;

    // Tags are a power-of-two ring, so plain RRF_SEL-bit arithmetic wraps modulo RRF_NUM.
    assign head1       = head_q + TAG_ONE;
    assign comptr_o    = head_q;
    assign comptr2_o   = head1;
    assign occupancy_o = occ_q;
    assign empty_o     = (occ_q == '0);
    assign full_o      = (occ_q == OCC_MAX);
    assign alloc_err_o = err_q;

    // Fullness is judged on pre-commit state: a slot freed this cycle is not reusable until next cycle.
    assign alloc_acc = dp_alloc_en_i && !full_o;

    always_comb begin
        com_en_o    = 2'b00;
        com_en_o[0] = !com_stall_i && (occ_q != '0) && valid_q[head_q] && fin_q[head_q];
        com_en_o[1] = com_en_o[0] && (occ_q >= OCC_TWO) && valid_q[head1] && fin_q[head1];
        com_inst_num_o = {1'b0, com_en_o[0]} + {1'b0, com_en_o[1]};
    end

    always_comb begin
        valid_d = valid_q;
        fin_d   = fin_q;
        // Finishes first, then commit clears, then allocation, so allocation wins a same-tag collision.
        if (ex_fin_en_i[0] && valid_q[ex_fin_tag0_i]) begin
            fin_d[ex_fin_tag0_i] = 1'b1;
        end
        if (ex_fin_en_i[1] && valid_q[ex_fin_tag1_i]) begin
            fin_d[ex_fin_tag1_i] = 1'b1;
        end
        if (com_en_o[0]) begin
            valid_d[head_q] = 1'b0;
            fin_d[head_q]   = 1'b0;
        end
        if (com_en_o[1]) begin
            valid_d[head1] = 1'b0;
            fin_d[head1]   = 1'b0;
        end
        if (alloc_acc) begin
            valid_d[tail_q] = 1'b1;
            fin_d[tail_q]   = 1'b0;
        end
    end

    always_comb begin
        head_d = head_q + RRF_SEL'(com_inst_num_o);
        tail_d = alloc_acc ? (tail_q + TAG_ONE) : tail_q;
        occ_d  = occ_q + (RRF_SEL+1)'(alloc_acc) - (RRF_SEL+1)'(com_inst_num_o);
        err_d  = err_q;
        if (dp_alloc_en_i && ((dp_alloc_tag_i != tail_q) || full_o)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q <= '0;
            fin_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            fin_q   <= fin_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rrf_commit_tracker.sv
// Self-checking bench for rrf_commit_tracker: directed scenarios plus randomized traffic
// compared against an in-order queue model of outstanding tags.
module tb_rrf_commit_tracker;

    localparam int N = 64;
    localparam int S = 6;

    logic         clk_i;
    logic         reset_i;
    logic         dp_alloc_en;
    logic [S-1:0] dp_alloc_tag;
    logic [1:0]   ex_fin_en;
    logic [S-1:0] ex_fin_tag0;
    logic [S-1:0] ex_fin_tag1;
    logic         com_stall;
    logic [1:0]   com_inst_num;
    logic [1:0]   com_en;
    logic [S-1:0] comptr;
    logic [S-1:0] comptr2;
    logic [S:0]   occupancy;
    logic         empty;
    logic         full;
    logic         alloc_err;

    int n_pass;
    int n_total;

    // Reference model: outstanding tags in allocation order plus per-tag finished flags.
    int q[$];
    bit m_valid[N];
    bit m_fin[N];
    int m_tail;
    bit m_err;

    rrf_commit_tracker #(.RRF_NUM(N), .RRF_SEL(S)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .dp_alloc_en_i  (dp_alloc_en),
        .dp_alloc_tag_i (dp_alloc_tag),
        .ex_fin_en_i    (ex_fin_en),
        .ex_fin_tag0_i  (ex_fin_tag0),
        .ex_fin_tag1_i  (ex_fin_tag1),
        .com_stall_i    (com_stall),
        .com_inst_num_o (com_inst_num),
        .com_en_o       (com_en),
        .comptr_o       (comptr),
        .comptr2_o      (comptr2),
        .occupancy_o    (occupancy),
        .empty_o        (empty),
        .full_o         (full),
        .alloc_err_o    (alloc_err)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [1:0] m_com_en();
        logic [1:0] e;
        e = 2'b00;
        if (!com_stall && q.size() >= 1 && m_fin[q[0]]) e[0] = 1'b1;
        if (e[0] && q.size() >= 2 && m_fin[q[1]]) e[1] = 1'b1;
        return e;
    endfunction

    function automatic int m_head();
        return (m_tail + N - q.size()) % N;
    endfunction

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_fin[i]   = 1'b0;
        end
        m_tail = 0;
        m_err  = 1'b0;
    endtask

    // Called at a falling edge; inputs settle before the next rising edge.
    task automatic drive(input logic ae, input int at, input logic [1:0] fe,
                         input int f0, input int f1, input logic st);
        dp_alloc_en  = ae;
        dp_alloc_tag = S'(at);
        ex_fin_en    = fe;
        ex_fin_tag0  = S'(f0);
        ex_fin_tag1  = S'(f1);
        com_stall    = st;
        #1;
    endtask

    task automatic tick();
        logic [1:0] e;
        bit fv0, fv1, full_m;
        e      = m_com_en();
        full_m = (q.size() == N);
        fv0    = ex_fin_en[0] && m_valid[ex_fin_tag0];
        fv1    = ex_fin_en[1] && m_valid[ex_fin_tag1];
        if (dp_alloc_en && ((int'(dp_alloc_tag) != m_tail) || full_m)) m_err = 1'b1;
        @(posedge clk_i);
        for (int k = 0; k < int'(e[0]) + int'(e[1]); k++) begin
            m_valid[q[0]] = 1'b0;
            m_fin[q[0]]   = 1'b0;
            void'(q.pop_front());
        end
        if (fv0) m_fin[ex_fin_tag0] = 1'b1;
        if (fv1) m_fin[ex_fin_tag1] = 1'b1;
        if (dp_alloc_en && !full_m) begin
            q.push_back(m_tail);
            m_valid[m_tail] = 1'b1;
            m_fin[m_tail]   = 1'b0;
            m_tail          = (m_tail + 1) % N;
        end
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        reset_i = 1'b0;
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if ({com_inst_num, com_en} !== 4'b0000) $display("FAIL reset_commit got=%b exp=0000", {com_inst_num, com_en});
        else n_pass++;
        n_total++;
        if (comptr !== 6'd0 || comptr2 !== 6'd1) $display("FAIL reset_ptrs got=%0d/%0d exp=0/1", comptr, comptr2);
        else n_pass++;
        n_total++;
        if ({occupancy, empty, full, alloc_err} !== {7'd0, 3'b100})
            $display("FAIL reset_status got occ=%0d e=%b f=%b err=%b exp occ=0 e=1 f=0 err=0", occupancy, empty, full, alloc_err);
        else n_pass++;
    endtask

    task automatic test_in_order();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 2'b00, 0, 0, 1'b0);
            tick();
        end
        drive(1'b0, 0, 2'b01, 1, 0, 1'b0);
        n_total++;
        if (com_en !== 2'b00) $display("FAIL order_none_before got=%b exp=00", com_en);
        else n_pass++;
        tick();
        drive(1'b0, 0, 2'b01, 0, 0, 1'b0);
        n_total++;
        if (com_en !== 2'b00) $display("FAIL order_tag1_only got=%b exp=00", com_en);
        else n_pass++;
        tick();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (com_inst_num !== 2'd2 || com_en !== 2'b11) $display("FAIL order_commit2 got num=%0d en=%b exp num=2 en=11", com_inst_num, com_en);
        else n_pass++;
        tick();
        n_total++;
        if (comptr !== 6'd2 || occupancy !== 7'd1) $display("FAIL order_after got ptr=%0d occ=%0d exp ptr=2 occ=1", comptr, occupancy);
        else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset();
        drive(1'b1, 0, 2'b00, 0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 2'b01, 0, 0, 1'b1);
        tick();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b1);
        n_total++;
        if (com_inst_num !== 2'd0) $display("FAIL stall_hold got=%0d exp=0", com_inst_num);
        else n_pass++;
        tick();
        n_total++;
        if (occupancy !== 7'd1) $display("FAIL stall_occ got=%0d exp=1", occupancy);
        else n_pass++;
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (com_inst_num !== 2'd1 || com_en !== 2'b01) $display("FAIL stall_release got num=%0d en=%b exp num=1 en=01", com_inst_num, com_en);
        else n_pass++;
        tick();
        n_total++;
        if (occupancy !== 7'd0 || empty !== 1'b1 || comptr !== 6'd1) $display("FAIL stall_drain got occ=%0d e=%b ptr=%0d exp 0/1/1", occupancy, empty, comptr);
        else n_pass++;
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < N; i++) begin
            drive(1'b1, i, 2'b00, 0, 0, 1'b0);
            tick();
        end
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (full !== 1'b1 || occupancy !== 7'd64 || alloc_err !== 1'b0)
            $display("FAIL full_reach got f=%b occ=%0d err=%b exp f=1 occ=64 err=0", full, occupancy, alloc_err);
        else n_pass++;
        drive(1'b1, 0, 2'b00, 0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (alloc_err !== 1'b1 || occupancy !== 7'd64) $display("FAIL full_overflow got err=%b occ=%0d exp err=1 occ=64", alloc_err, occupancy);
        else n_pass++;
        drive(1'b0, 0, 2'b01, 0, 0, 1'b0);
        tick();
        drive(1'b1, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (com_inst_num !== 2'd1) $display("FAIL full_commit got=%0d exp=1", com_inst_num);
        else n_pass++;
        tick();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (occupancy !== 7'd63 || full !== 1'b0 || comptr !== 6'd1)
            $display("FAIL full_alloc_blocked got occ=%0d f=%b ptr=%0d exp occ=63 f=0 ptr=1", occupancy, full, comptr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < N - 1; i++) begin
            drive(1'b1, i, (i > 0) ? 2'b01 : 2'b00, (i > 0) ? i - 1 : 0, 0, 1'b0);
            tick();
        end
        drive(1'b0, 0, 2'b01, N - 2, 0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
            tick();
        end
        n_total++;
        if (comptr !== 6'd63 || occupancy !== 7'd0) $display("FAIL wrap_setup got ptr=%0d occ=%0d exp ptr=63 occ=0", comptr, occupancy);
        else n_pass++;
        drive(1'b1, 63, 2'b00, 0, 0, 1'b0);
        tick();
        drive(1'b1, 0, 2'b00, 0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 2'b11, 63, 0, 1'b0);
        tick();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (com_en !== 2'b11 || comptr2 !== 6'd0) $display("FAIL wrap_commit got en=%b ptr2=%0d exp en=11 ptr2=0", com_en, comptr2);
        else n_pass++;
        tick();
        n_total++;
        if (comptr !== 6'd1 || occupancy !== 7'd0 || alloc_err !== 1'b0)
            $display("FAIL wrap_after got ptr=%0d occ=%0d err=%b exp ptr=1 occ=0 err=0", comptr, occupancy, alloc_err);
        else n_pass++;
    endtask

    task automatic test_random();
        logic ae, st;
        logic [1:0] fe, e;
        int at, f0, f1, h;
        logic [25:0] exp_v, obs_v;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            ae = ($urandom_range(0, 99) < 60);
            at = ($urandom_range(0, 99) < 2) ? int'($urandom_range(0, N - 1)) : m_tail;
            fe = 2'($urandom_range(0, 3));
            f0 = (q.size() > 0 && $urandom_range(0, 9) > 0) ? q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, N - 1));
            f1 = (q.size() > 0 && $urandom_range(0, 9) > 0) ? q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, N - 1));
            st = ($urandom_range(0, 99) < 15);
            drive(ae, at, fe, f0, f1, st);
            e = m_com_en();
            h = m_head();
            exp_v = {e, 2'(int'(e[0]) + int'(e[1])), S'(h), S'((h + 1) % N), 7'(q.size()),
                     q.size() == 0, q.size() == N, m_err};
            obs_v = {com_en, com_inst_num, comptr, comptr2, occupancy, empty, full, alloc_err};
            n_total++;
            if (obs_v !== exp_v) $display("FAIL random_cycle%0d got=%h exp=%h", c, obs_v, exp_v);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i, 2'b00, 0, 0, 1'b1);
            tick();
        end
        drive(1'b0, 0, 2'b11, 0, 1, 1'b1);
        tick();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (com_en !== 2'b11 || occupancy !== 7'd10) $display("FAIL areset_pre got en=%b occ=%0d exp en=11 occ=10", com_en, occupancy);
        else n_pass++;
        #2;
        reset_i = 1'b0;
        #1;
        n_total++;
        if ({com_inst_num, com_en, comptr, comptr2, occupancy, empty, full, alloc_err} !== {4'b0000, 6'd0, 6'd1, 7'd0, 3'b100})
            $display("FAIL areset_now got num=%0d en=%b ptr=%0d ptr2=%0d occ=%0d e=%b f=%b err=%b exp 0/00/0/1/0/1/0/0",
                     com_inst_num, com_en, comptr, comptr2, occupancy, empty, full, alloc_err);
        else n_pass++;
        @(negedge clk_i);
        reset_i = 1'b1;
        model_clear();
        drive(1'b0, 0, 2'b11, 0, 1, 1'b0);
        tick();
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        n_total++;
        if (com_en !== 2'b00 || occupancy !== 7'd0) $display("FAIL areset_after got en=%b occ=%0d exp en=00 occ=0", com_en, occupancy);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_i = 1'b0;
        drive(1'b0, 0, 2'b00, 0, 0, 1'b0);
        model_clear();
        test_reset();
        test_in_order();
        test_stall();
        test_full();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
